// File: rtl/reg_file_f_wb_ctrl.sv
// FP register-file write-back controller: arbitrates FPU and load results onto the
// single write port and keeps a per-register pending scoreboard for decode hazards.
module reg_file_f_wb_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid_i,
    input  logic [4:0]            issue_rd_i,
    input  logic [4:0]            issue_rs1_i,
    input  logic [4:0]            issue_rs2_i,
    input  logic [4:0]            issue_rs3_i,
    input  logic [2:0]            issue_rs_use_i,
    output logic                  hazard_o,
    output logic                  issue_ack_o,
    input  logic                  fpu_valid_i,
    input  logic [4:0]            fpu_rd_i,
    input  logic [DATA_WIDTH-1:0] fpu_data_i,
    output logic                  fpu_ready_o,
    input  logic                  ld_valid_i,
    input  logic [4:0]            ld_rd_i,
    input  logic [DATA_WIDTH-1:0] ld_data_i,
    output logic                  ld_ready_o,
    output logic                  regfile_we_o,
    output logic [4:0]            regfile_waddr_o,
    output logic [DATA_WIDTH-1:0] regfile_data_o,
    output logic [NUM_REGS-1:0]   pending_o,
    output logic                  spurious_o
);

    localparam logic GRANT_FPU = 1'b0;
    localparam logic GRANT_LD  = 1'b1;

    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic                  we_q, we_d;
    logic [4:0]            waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_grant_q, last_grant_d;
    logic                  spurious_q, spurious_d;
    logic                  hazard_s;
    logic                  ack_s;
    logic                  fpu_grant_s;
    logic                  ld_grant_s;

    // Hazard covers RAW on enabled sources and WAW on the destination.
    always_comb begin
        hazard_s = pending_q[issue_rd_i]
                 | (issue_rs_use_i[0] & pending_q[issue_rs1_i])
                 | (issue_rs_use_i[1] & pending_q[issue_rs2_i])
                 | (issue_rs_use_i[2] & pending_q[issue_rs3_i]);
        ack_s    = issue_valid_i & ~hazard_s & ~rst;
    end

    // Round-robin grant: on a tie, the requester not granted last time wins.
    always_comb begin
        fpu_grant_s = 1'b0;
        ld_grant_s  = 1'b0;
        if (rst) begin
            fpu_grant_s = 1'b0;
            ld_grant_s  = 1'b0;
        end else if (fpu_valid_i && ld_valid_i) begin
            fpu_grant_s = (last_grant_q == GRANT_LD);
            ld_grant_s  = (last_grant_q == GRANT_FPU);
        end else begin
            fpu_grant_s = fpu_valid_i;
            ld_grant_s  = ld_valid_i;
        end
    end

    // Next-state: scoreboard clear/set (set applied last so it wins), write-port staging.
    always_comb begin
        pending_d    = pending_q;
        we_d         = fpu_grant_s | ld_grant_s;
        waddr_d      = 5'd0;
        data_d       = {DATA_WIDTH{1'b0}};
        last_grant_d = last_grant_q;
        spurious_d   = spurious_q;
        if (we_q) begin
            pending_d[waddr_q] = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (ack_s) begin
            pending_d[issue_rd_i] = 1'b1;
        end else begin
            pending_d = pending_d;
        end
        if (fpu_grant_s) begin
            waddr_d      = fpu_rd_i;
            data_d       = fpu_data_i;
            last_grant_d = GRANT_FPU;
            spurious_d   = spurious_q | ~pending_q[fpu_rd_i];
        end else if (ld_grant_s) begin
            waddr_d      = ld_rd_i;
            data_d       = ld_data_i;
            last_grant_d = GRANT_LD;
            spurious_d   = spurious_q | ~pending_q[ld_rd_i];
        end else begin
            waddr_d      = 5'd0;
            data_d       = {DATA_WIDTH{1'b0}};
        end
    end

    // State registers; reset leaves last_grant at LD so the FPU wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q    <= {NUM_REGS{1'b0}};
            we_q         <= 1'b0;
            waddr_q      <= 5'd0;
            data_q       <= {DATA_WIDTH{1'b0}};
            last_grant_q <= GRANT_LD;
            spurious_q   <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            data_q       <= data_d;
            last_grant_q <= last_grant_d;
            spurious_q   <= spurious_d;
        end
    end

    assign hazard_o        = hazard_s;
    assign issue_ack_o     = ack_s;
    assign fpu_ready_o     = fpu_grant_s;
    assign ld_ready_o      = ld_grant_s;
    assign regfile_we_o    = we_q;
    assign regfile_waddr_o = waddr_q;
    assign regfile_data_o  = data_q;
    assign pending_o       = pending_q;
    assign spurious_o      = spurious_q;

endmodule

// File: doc/reg_file_f_wb_ctrl.md
Name: reg_file_f_wb_ctrl

Overview:
- Write-back controller and scoreboard for the 32-entry FP register file.
- Arbitrates the FP register file's single write port between two result producers: the multi-cycle FPU and the FP load path (FLW).
- Tracks pending destination registers and raises a hazard flag for the decoder, so dependent FP instructions stall until their operands are written.
- Sits between the decode stage and the FP register file write port.

Parameters:
- DATA_WIDTH, 32, width of FP register data (matches `DATA_WIDTH).
- NUM_REGS, 32, number of FP registers; address width is fixed at 5.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- issue_valid_i  in  1  decoder presents an FP-writing instruction.
- issue_rd_i  in  5  destination f-register of the issuing instruction.
- issue_rs1_i  in  5  source register 1 address.
- issue_rs2_i  in  5  source register 2 address.
- issue_rs3_i  in  5  source register 3 address.
- issue_rs_use_i  in  3  per-source enable: bit0 rs1, bit1 rs2, bit2 rs3.
- hazard_o  out  1  combinational: issue must stall this cycle.
- issue_ack_o  out  1  combinational: issue_valid_i && !hazard_o.
- fpu_valid_i  in  1  FPU result ready.
- fpu_rd_i  in  5  FPU result destination.
- fpu_data_i  in  DATA_WIDTH  FPU result data.
- fpu_ready_o  out  1  FPU result accepted this cycle.
- ld_valid_i  in  1  load result ready.
- ld_rd_i  in  5  load result destination.
- ld_data_i  in  DATA_WIDTH  load result data.
- ld_ready_o  out  1  load result accepted this cycle.
- regfile_we_o  out  1  registered write enable to the register file.
- regfile_waddr_o  out  5  registered write address.
- regfile_data_o  out  DATA_WIDTH  registered write data.
- pending_o  out  NUM_REGS  scoreboard bits; bit i = write to f[i] outstanding.
- spurious_o  out  1  sticky: a result targeted a non-pending register.

Behaviour:

Reset (synchronous, rst=1 at a rising edge):
- pending_o=0, regfile_we_o=0, regfile_waddr_o=0, regfile_data_o=0, spurious_o=0, last_grant=LD (so the FPU wins the first tie).
- While rst=1: fpu_ready_o=0, ld_ready_o=0, issue_ack_o=0; hazard_o still reflects pending_o.
- Reset mid-operation drops any in-flight grant; the register file receives no write on the following cycle.

Hazard:
- hazard_o = (pending[issue_rd_i]) | (use[0] & pending[rs1]) | (use[1] & pending[rs2]) | (use[2] & pending[rs3]).
- Covers both RAW and WAW hazards.
- hazard_o is driven for any issue_valid_i; it is don't-care when issue_valid_i=0.

Issue:
- When issue_ack_o=1, pending[issue_rd_i] is set at the next edge.

Arbitration:
- Evaluated each cycle, combinational grant.
- Only one valid requester: that requester is granted.
- Both valid: round-robin; grant the requester that is not last_grant.
- last_grant updates on every grant.
- A requester holds valid, rd and data stable until its ready is seen.
- fpu_ready_o / ld_ready_o = grant to that requester.

Write:
- One cycle after a grant, regfile_we_o=1 with the granted rd and data.
- Latency: grant in cycle N, register-file write at the end of cycle N+1.
- With back-to-back grants, regfile_we_o stays high continuously.

Scoreboard clear:
- pending[regfile_waddr_o] clears at the edge that ends a regfile_we_o=1 cycle.
- Hazard release is therefore visible in cycle N+2.

Simultaneous events:
- Set and clear of the same bit at the same edge: set wins. This is unreachable by construction, but must still be implemented.
- Set and clear of different bits at the same edge: both take effect.

Spurious result:
- A granted result with pending[rd]=0 is still written.
- spurious_o sets and stays set until reset.

Test Plan:
- Reset: assert rst for 2 cycles with both producers valid -> readies 0, regfile_we_o=0, pending_o=0 in the cycle after release, spurious_o=0.
- Single FPU op: issue rd=5 (ack=1) -> pending_o[5]=1; fpu_valid rd=5, data=0x3F800000 -> fpu_ready_o=1 same cycle; next cycle regfile_we_o=1, waddr=5, data=0x3F800000; following cycle pending_o[5]=0.
- RAW stall: f3 pending; issue rd=7 with rs2=3, use=3'b010 -> hazard_o=1, ack=0, pending_o[7] unchanged. The same issue with use=3'b001 and rs1=4 (not pending) -> ack=1.
- WAW stall: f9 pending; issue rd=9 with no sources used -> hazard_o=1.
- Contention: f1 and f2 pending; FPU rd=1 and LD rd=2 both valid from the cycle after reset -> FPU granted first, LD next cycle; regfile_we_o high for 2 consecutive cycles with waddr 1 then 2.
- Fairness under sustained contention: both requesters re-assert immediately for 4 results each -> grants strictly alternate (FPU, LD, FPU, LD, ...).
- Spurious: ld_valid rd=12 with pending_o[12]=0 -> write occurs; spurious_o=1 thereafter until rst.
